id_stage_pipe: RTL and testbench

- Parametrised successor to the single-register decode stage; sits between decode and execute.
- Carries a control word plus data payload through a 2-entry skid buffer with a valid/ready handshake, synchronous flush, and back-pressure to decode.
- Detects trap-always (ta) instructions on a configurable control bit, emits a one-cycle ta pulse, and squashes a configurable number of following accepted beats.

---
 rtl/id_stage_pipe.sv | 129 ++++++++++++
 tb/tb_id_stage_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode-to-execute pipeline stage: 2-entry skid buffer with valid/ready handshake,
// synchronous flush and trap-always detection that squashes a run of following beats.
module id_stage_pipe #(
  parameter int CW          = 17,
  parameter int DW          = 32,
  parameter int TA_BIT      = 7,
  parameter int TRAP_SQUASH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data,
  output logic          ta_instr,
  output logic          squash_active
);

  localparam int CNT_W = (TRAP_SQUASH > 0) ? $clog2(TRAP_SQUASH + 1) : 1;
  localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(TRAP_SQUASH);

  logic          main_valid_r, skid_valid_r, in_ready_r, ta_instr_r, squash_active_r;
  logic [CW-1:0] main_ctrl_r, skid_ctrl_r;
  logic [DW-1:0] main_data_r, skid_data_r;
  logic [CNT_W-1:0] sq_cnt_r;

  logic          main_valid_nxt_s, skid_valid_nxt_s, ta_nxt_s;
  logic [CW-1:0] main_ctrl_nxt_s, skid_ctrl_nxt_s;
  logic [DW-1:0] main_data_nxt_s, skid_data_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic accept_s, xfer_s, squashing_s, store_s, is_ta_s;

  assign accept_s    = in_valid & in_ready_r;
  assign xfer_s      = main_valid_r & out_ready;
  assign squashing_s = (sq_cnt_r != {CNT_W{1'b0}});
  // Squashed beats are consumed (handshake completes) but never written into storage.
  assign store_s     = accept_s & ~squashing_s & ~flush;
  assign is_ta_s     = in_ctrl[TA_BIT];

  // Next-state logic for storage entries, squash counter and ta pulse.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    main_ctrl_nxt_s  = main_ctrl_r;
    main_data_nxt_s  = main_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_ctrl_nxt_s  = skid_ctrl_r;
    skid_data_nxt_s  = skid_data_r;
    cnt_nxt_s        = sq_cnt_r;
    ta_nxt_s         = 1'b0;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
      cnt_nxt_s        = {CNT_W{1'b0}};
    end else begin
      ta_nxt_s = store_s & is_ta_s;
      if (accept_s && squashing_s) begin
        cnt_nxt_s = sq_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (store_s && is_ta_s) begin
        cnt_nxt_s = SQ_LOAD;
      end else begin
        cnt_nxt_s = sq_cnt_r;
      end

      if (xfer_s && skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = skid_ctrl_r;
        main_data_nxt_s  = skid_data_r;
        skid_valid_nxt_s = 1'b0;
      end else if (xfer_s && store_s) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = in_ctrl;
        main_data_nxt_s  = in_data;
      end else if (xfer_s) begin
        main_valid_nxt_s = 1'b0;
      end else if (!main_valid_r && store_s) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = in_ctrl;
        main_data_nxt_s  = in_data;
      end else if (store_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_ctrl_nxt_s  = in_ctrl;
        skid_data_nxt_s  = in_data;
      end else begin
        main_valid_nxt_s = main_valid_r;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_r    <= 1'b0;
      main_ctrl_r     <= {CW{1'b0}};
      main_data_r     <= {DW{1'b0}};
      skid_valid_r    <= 1'b0;
      skid_ctrl_r     <= {CW{1'b0}};
      skid_data_r     <= {DW{1'b0}};
      in_ready_r      <= 1'b1;
      ta_instr_r      <= 1'b0;
      sq_cnt_r        <= {CNT_W{1'b0}};
      squash_active_r <= 1'b0;
    end else begin
      main_valid_r    <= main_valid_nxt_s;
      main_ctrl_r     <= main_ctrl_nxt_s;
      main_data_r     <= main_data_nxt_s;
      skid_valid_r    <= skid_valid_nxt_s;
      skid_ctrl_r     <= skid_ctrl_nxt_s;
      skid_data_r     <= skid_data_nxt_s;
      in_ready_r      <= ~skid_valid_nxt_s;
      ta_instr_r      <= ta_nxt_s;
      sq_cnt_r        <= cnt_nxt_s;
      squash_active_r <= (cnt_nxt_s != {CNT_W{1'b0}});
    end
  end

  assign in_ready      = in_ready_r;
  assign out_valid     = main_valid_r;
  assign out_ctrl      = main_ctrl_r;
  assign out_data      = main_data_r;
  assign ta_instr      = ta_instr_r;
  assign squash_active = squash_active_r;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed table-driven bench for id_stage_pipe: one TRAP_SQUASH=2 instance and one
// TRAP_SQUASH=0 instance, plus a hand-written asynchronous reset sequence.
module tb_id_stage_pipe;

  typedef struct {
    logic        iv;
    logic [16:0] ctrl;
    logic        fl;
    logic        ordy;
    logic        ov;
    logic [16:0] oc;
    logic        ir;
    logic        ta;
    logic        sa;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        in_valid, in_ready, flush, out_valid, out_ready, ta_instr, squash_active;
  logic [16:0] in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data;

  logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0, ta_instr0, squash_active0;
  logic [16:0] in_ctrl0, out_ctrl0;
  logic [31:0] in_data0, out_data0;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t tbl0[$];

  always #5 clk = ~clk;

  id_stage_pipe #(.CW(17), .DW(32), .TA_BIT(7), .TRAP_SQUASH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .ta_instr(ta_instr), .squash_active(squash_active)
  );

  id_stage_pipe #(.CW(17), .DW(32), .TA_BIT(7), .TRAP_SQUASH(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .flush(flush0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .ta_instr(ta_instr0), .squash_active(squash_active0)
  );

  function automatic vec_t mk(logic iv, logic [16:0] c, logic fl, logic ordy,
                              logic ov, logic [16:0] oc, logic ir, logic ta, logic sa);
    vec_t v;
    v.iv = iv; v.ctrl = c; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.oc = oc; v.ir = ir; v.ta = ta; v.sa = sa;
    return v;
  endfunction

  function automatic logic [31:0] data_of(logic [16:0] c);
    return {15'h6800, c};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic sel, logic ov, logic [16:0] oc,
                            logic ir, logic ta, logic sa);
    logic a_ov, a_ir, a_ta, a_sa;
    logic [16:0] a_oc;
    logic [31:0] a_od;
    if (sel) begin
      a_ov = out_valid0; a_oc = out_ctrl0; a_od = out_data0;
      a_ir = in_ready0;  a_ta = ta_instr0; a_sa = squash_active0;
    end else begin
      a_ov = out_valid;  a_oc = out_ctrl;  a_od = out_data;
      a_ir = in_ready;   a_ta = ta_instr;  a_sa = squash_active;
    end
    chk({tag, "_out_valid"}, 64'(a_ov), 64'(ov));
    if (ov) begin
      chk({tag, "_out_ctrl"}, 64'(a_oc), 64'(oc));
      chk({tag, "_out_data"}, 64'(a_od), 64'(data_of(oc)));
    end
    chk({tag, "_in_ready"}, 64'(a_ir), 64'(ir));
    chk({tag, "_ta_instr"}, 64'(a_ta), 64'(ta));
    chk({tag, "_squash_active"}, 64'(a_sa), 64'(sa));
  endtask

  task automatic run_vec(string tag, vec_t v, logic sel);
    @(negedge clk);
    if (sel) begin
      in_valid0 = v.iv; in_ctrl0 = v.ctrl; in_data0 = data_of(v.ctrl);
      flush0 = v.fl; out_ready0 = v.ordy;
    end else begin
      in_valid = v.iv; in_ctrl = v.ctrl; in_data = data_of(v.ctrl);
      flush = v.fl; out_ready = v.ordy;
    end
    @(posedge clk);
    #1;
    check_outs(tag, sel, v.ov, v.oc, v.ir, v.ta, v.sa);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_ctrl = 17'h0; in_data = 32'h0; flush = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_ctrl0 = 17'h0; in_data0 = 32'h0; flush0 = 1'b0; out_ready0 = 1'b0;

    //            iv  ctrl       fl    ordy  ov    oc         ir    ta    sa
    tbl.push_back(mk(1'b1, 17'h00001, 1'b0, 1'b1, 1'b1, 17'h00001, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00002, 1'b0, 1'b1, 1'b1, 17'h00002, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00003, 1'b0, 1'b1, 1'b1, 17'h00003, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00010, 1'b0, 1'b0, 1'b1, 17'h00010, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00020, 1'b0, 1'b0, 1'b1, 17'h00010, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00030, 1'b0, 1'b0, 1'b1, 17'h00010, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 17'h00020, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b1, 1'b1, 17'h00080, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 17'h00001, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 17'h00002, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00003, 1'b0, 1'b1, 1'b1, 17'h00003, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b1, 1'b1, 17'h00080, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 17'h00005, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00006, 1'b0, 1'b1, 1'b1, 17'h00006, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00040, 1'b0, 1'b0, 1'b1, 17'h00040, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b0, 1'b1, 17'h00040, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b1, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b0, 1'b1, 17'h00080, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 17'h00007, 1'b0, 1'b0, 1'b1, 17'h00080, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 17'h00008, 1'b1, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00080, 1'b1, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 17'h00009, 1'b0, 1'b1, 1'b1, 17'h00009, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));

    tbl0.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b1, 1'b1, 17'h00080, 1'b1, 1'b1, 1'b0));
    tbl0.push_back(mk(1'b1, 17'h00080, 1'b0, 1'b1, 1'b1, 17'h00080, 1'b1, 1'b1, 1'b0));
    tbl0.push_back(mk(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 17'h0, 1'b1, 1'b0, 1'b0);
    chk("reset_out_ctrl", 64'(out_ctrl), 64'h0);
    chk("reset_out_data", 64'(out_data), 64'h0);
    check_outs("reset0", 1'b1, 1'b0, 17'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("v%0d", i), tbl[i], 1'b0);
    end

    // Asynchronous reset with a valid ta beat held in main.
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 17'h1ABCD; in_data = data_of(17'h1ABCD);
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_outs("pre_rst", 1'b0, 1'b1, 17'h1ABCD, 1'b1, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 17'h0, 1'b1, 1'b0, 1'b0);
    chk("async_rst_out_ctrl", 64'(out_ctrl), 64'h0);
    chk("async_rst_out_data", 64'(out_data), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_ctrl = 17'h00042; in_data = data_of(17'h00042); out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_rst", 1'b0, 1'b1, 17'h00042, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;

    for (int j = 0; j < tbl0.size(); j++) begin
      run_vec($sformatf("ts0_v%0d", j), tbl0[j], 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
